// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage with a request/grant/response data-memory
// port and the MEM/WB pipeline registers.
//
// Ports
//   clk, rst              : clock (rising edge) and asynchronous active-high reset
//   i_*_M                 : instruction fields presented by EX/MEM
//   o_dmem_req/we/addr/wdata : data-memory request (addr is a raw byte address)
//   i_dmem_gnt            : request accepted this cycle
//   i_dmem_rvalid/rdata   : response (loads and stores both get one)
//   o_stall_M             : hold the upstream pipeline registers this cycle
//   o_*_W                 : MEM/WB registers (bubble while stalled)
//
// A memory op is issued combinationally from IDLE so that a grant in the same
// cycle costs nothing; the instruction is latched at that edge and only the
// latched copy is used until the response retires it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_alu_result_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  input  logic [DATA_WIDTH-1:0] i_pc_plus4_M,
  input  logic [REG_WIDTH-1:0]  i_rd_M,
  input  logic                  i_reg_write_M,
  input  logic [1:0]            i_result_src_M,
  input  logic                  i_mem_write_M,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [DATA_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  input  logic                  i_dmem_gnt,
  input  logic                  i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic                  o_stall_M,
  output logic [DATA_WIDTH-1:0] o_alu_result_W,
  output logic [DATA_WIDTH-1:0] o_read_data_W,
  output logic [DATA_WIDTH-1:0] o_pc_plus4_W,
  output logic [REG_WIDTH-1:0]  o_rd_W,
  output logic                  o_reg_write_W,
  output logic [1:0]            o_result_src_W
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_next;

  // Latched copy of the instruction that owns the memory transaction
  logic [DATA_WIDTH-1:0] lat_alu, lat_wdata, lat_pc;
  logic [REG_WIDTH-1:0]  lat_rd;
  logic                  lat_reg_write, lat_we;
  logic [1:0]            lat_result_src;
  logic                  latch_en;

  // Next values for the MEM/WB registers (all-zero means bubble)
  logic [DATA_WIDTH-1:0] w_alu, w_read, w_pc;
  logic [REG_WIDTH-1:0]  w_rd;
  logic                  w_reg_write;
  logic [1:0]            w_result_src;

  logic mem_op;
  // A store wins when both store and load encodings are present; it is still
  // one memory op, issued as a write.
  assign mem_op = i_mem_write_M | (i_result_src_M == 2'b01);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, memory request, stall and MEM/WB next-value selection
  always_comb begin
    state_next   = state;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_wdata = '0;
    o_stall_M    = 1'b0;
    latch_en     = 1'b0;
    w_alu        = '0;
    w_read       = '0;
    w_pc         = '0;
    w_rd         = '0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    case (state)
      IDLE: begin
        if (mem_op) begin
          o_dmem_req   = 1'b1;
          o_dmem_we    = i_mem_write_M;
          o_dmem_addr  = i_alu_result_M;
          o_dmem_wdata = i_write_data_M;
          o_stall_M    = 1'b1;
          latch_en     = 1'b1;
          state_next   = i_dmem_gnt ? WAIT : REQ;
        end else begin
          w_alu        = i_alu_result_M;
          w_pc         = i_pc_plus4_M;
          w_rd         = i_rd_M;
          w_reg_write  = i_reg_write_M;
          w_result_src = i_result_src_M;
        end
      end
      REQ: begin
        o_dmem_req   = 1'b1;
        o_dmem_we    = lat_we;
        o_dmem_addr  = lat_alu;
        o_dmem_wdata = lat_wdata;
        o_stall_M    = 1'b1;
        if (i_dmem_gnt) begin
          state_next = WAIT;
        end else begin
          state_next = REQ;
        end
      end
      WAIT: begin
        if (i_dmem_rvalid) begin
          // Retire: the upstream pipeline may advance in this same cycle
          w_alu        = lat_alu;
          w_read       = lat_we ? '0 : i_dmem_rdata;
          w_pc         = lat_pc;
          w_rd         = lat_rd;
          w_reg_write  = lat_reg_write;
          w_result_src = lat_result_src;
          state_next   = IDLE;
        end else begin
          o_stall_M  = 1'b1;
          state_next = WAIT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Instruction latch, loaded when a memory op leaves IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_alu        <= '0;
      lat_wdata      <= '0;
      lat_pc         <= '0;
      lat_rd         <= '0;
      lat_reg_write  <= 1'b0;
      lat_we         <= 1'b0;
      lat_result_src <= 2'b00;
    end else if (latch_en) begin
      lat_alu        <= i_alu_result_M;
      lat_wdata      <= i_write_data_M;
      lat_pc         <= i_pc_plus4_M;
      lat_rd         <= i_rd_M;
      lat_reg_write  <= i_reg_write_M;
      lat_we         <= i_mem_write_M;
      lat_result_src <= i_result_src_M;
    end else begin
      lat_alu        <= lat_alu;
      lat_wdata      <= lat_wdata;
      lat_pc         <= lat_pc;
      lat_rd         <= lat_rd;
      lat_reg_write  <= lat_reg_write;
      lat_we         <= lat_we;
      lat_result_src <= lat_result_src;
    end
  end

  // MEM/WB pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_alu_result_W <= '0;
      o_read_data_W  <= '0;
      o_pc_plus4_W   <= '0;
      o_rd_W         <= '0;
      o_reg_write_W  <= 1'b0;
      o_result_src_W <= 2'b00;
    end else begin
      o_alu_result_W <= w_alu;
      o_read_data_W  <= w_read;
      o_pc_plus4_W   <= w_pc;
      o_rd_W         <= w_rd;
      o_reg_write_W  <= w_reg_write;
      o_result_src_W <= w_result_src;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, wd, pc;
  logic [3:0]  rd;
  logic        rw, mw, gnt, rvalid;
  logic [1:0]  src;
  logic [31:0] rdata;
  logic        dreq, dwe, stall;
  logic [31:0] daddr, dwdata;
  logic [31:0] alu_w, read_w, pc_w;
  logic [3:0]  rd_w;
  logic        rw_w;
  logic [1:0]  src_w;

  mem_stage #(.DATA_WIDTH(32), .REG_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_alu_result_M(alu), .i_write_data_M(wd), .i_pc_plus4_M(pc),
    .i_rd_M(rd), .i_reg_write_M(rw), .i_result_src_M(src), .i_mem_write_M(mw),
    .o_dmem_req(dreq), .o_dmem_we(dwe), .o_dmem_addr(daddr), .o_dmem_wdata(dwdata),
    .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
    .o_stall_M(stall),
    .o_alu_result_W(alu_w), .o_read_data_W(read_w), .o_pc_plus4_W(pc_w),
    .o_rd_W(rd_w), .o_reg_write_W(rw_w), .o_result_src_W(src_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, wd, pc;
    logic [3:0]  rd;
    logic        rw;
    logic [1:0]  src;
    logic        mw;
  } instr_t;

  typedef struct {
    logic [31:0] alu, wd, pc;
    logic [3:0]  rd;
    logic        rw;
    logic [1:0]  src;
    logic        mw, g, rv;
    logic [31:0] rdt;
    logic [31:0] e_alu, e_pc;
    logic [3:0]  e_rd;
    logic        e_rw;
    logic [1:0]  e_src;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: at most one outstanding memory instruction, which is
  // either still waiting to be accepted or accepted and awaiting its response.
  instr_t pending[$];
  bit     accepted;
  logic   last_req, last_stall;

  function automatic instr_t mk(input logic [31:0] a, input logic [31:0] w,
                                input logic [31:0] p, input logic [3:0] r,
                                input logic regw, input logic [1:0] s, input logic st);
    instr_t t;
    t.alu = a; t.wd = w; t.pc = p; t.rd = r; t.rw = regw; t.src = s; t.mw = st;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle: starts and ends at a falling edge.
  task automatic step(input instr_t ins, input logic g, input logic rv, input logic [31:0] rdt);
    logic e_req, e_we, e_stall;
    logic [31:0] e_addr, e_wd;
    instr_t nw;
    logic [31:0] n_read;
    bit is_mem;
    alu = ins.alu; wd = ins.wd; pc = ins.pc; rd = ins.rd; rw = ins.rw;
    src = ins.src; mw = ins.mw; gnt = g; rvalid = rv; rdata = rdt;
    #1;
    is_mem = ins.mw || (ins.src == 2'b01);
    e_req = 1'b0; e_we = 1'b0; e_stall = 1'b0; e_addr = 32'h0; e_wd = 32'h0;
    nw = mk(32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00, 1'b0);
    n_read = 32'h0;
    if (pending.size() == 0) begin
      if (is_mem) begin
        e_req = 1'b1; e_we = ins.mw; e_addr = ins.alu; e_wd = ins.wd; e_stall = 1'b1;
        pending.push_back(ins);
        accepted = g;
      end else begin
        nw = ins;
      end
    end else if (!accepted) begin
      e_req = 1'b1; e_we = pending[0].mw; e_addr = pending[0].alu;
      e_wd = pending[0].wd; e_stall = 1'b1;
      if (g) accepted = 1'b1;
    end else if (rv) begin
      nw = pending.pop_front();
      n_read = nw.mw ? 32'h0 : rdt;
      accepted = 1'b0;
    end else begin
      e_stall = 1'b1;
    end
    last_req = dreq; last_stall = stall;
    chk("dmem_req", {31'h0, dreq}, {31'h0, e_req});
    chk("dmem_we", {31'h0, dwe}, {31'h0, e_we});
    chk("dmem_addr", daddr, e_addr);
    chk("dmem_wdata", dwdata, e_wd);
    chk("stall", {31'h0, stall}, {31'h0, e_stall});
    @(posedge clk);
    #1;
    chk("alu_W", alu_w, nw.alu);
    chk("read_W", read_w, n_read);
    chk("pc_W", pc_w, nw.pc);
    chk("rd_W", {28'h0, rd_w}, {28'h0, nw.rd});
    chk("regwrite_W", {31'h0, rw_w}, {31'h0, nw.rw});
    chk("src_W", {30'h0, src_w}, {30'h0, nw.src});
    @(negedge clk);
  endtask

  task automatic zero_w_checks(input string tag);
    chk({tag, "_alu_W"}, alu_w, 32'h0);
    chk({tag, "_read_W"}, read_w, 32'h0);
    chk({tag, "_pc_W"}, pc_w, 32'h0);
    chk({tag, "_rd_W"}, {28'h0, rd_w}, 32'h0);
    chk({tag, "_regwrite_W"}, {31'h0, rw_w}, 32'h0);
    chk({tag, "_src_W"}, {30'h0, src_w}, 32'h0);
  endtask

  // Reset pulse: starts and ends at a falling edge.
  task automatic do_reset();
    alu = 32'h0; wd = 32'h0; pc = 32'h0; rd = 4'h0; rw = 1'b0; src = 2'b00;
    mw = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    rst = 1'b1;
    #1;
    pending.delete();
    accepted = 1'b0;
    zero_w_checks("rst");
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_req", {31'h0, dreq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t   vecs[5];
  instr_t ld, ld2, st, idle_op;
  int     req_cnt, stall_cnt, rw_cnt;

  initial begin
    vecs[0] = '{32'h10, 32'h0, 32'h1004, 4'd3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,
                32'h10, 32'h1004, 4'd3, 1'b1, 2'b00};
    vecs[1] = '{32'hAAAA, 32'h1234, 32'h2008, 4'd7, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0,
                32'hAAAA, 32'h2008, 4'd7, 1'b1, 2'b10};
    vecs[2] = '{32'h55, 32'h0, 32'h300C, 4'd9, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0,
                32'h55, 32'h300C, 4'd9, 1'b1, 2'b11};
    vecs[3] = '{32'h77, 32'h0, 32'h4010, 4'd2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF,
                32'h77, 32'h4010, 4'd2, 1'b1, 2'b00};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0, 32'h14, 4'd15, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h1,
                32'hFFFF_FFFF, 32'h14, 4'd15, 1'b0, 2'b00};

    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Table vectors: non-memory ops in IDLE, stray gnt/rvalid ignored
    for (int i = 0; i < 5; i++) begin
      step(mk(vecs[i].alu, vecs[i].wd, vecs[i].pc, vecs[i].rd, vecs[i].rw, vecs[i].src,
              vecs[i].mw), vecs[i].g, vecs[i].rv, vecs[i].rdt);
      chk("vec_req", {31'h0, last_req}, 32'h0);
      chk("vec_stall", {31'h0, last_stall}, 32'h0);
      chk("vec_alu_W", alu_w, vecs[i].e_alu);
      chk("vec_read_W", read_w, 32'h0);
      chk("vec_pc_W", pc_w, vecs[i].e_pc);
      chk("vec_rd_W", {28'h0, rd_w}, {28'h0, vecs[i].e_rd});
      chk("vec_regwrite_W", {31'h0, rw_w}, {31'h0, vecs[i].e_rw});
      chk("vec_src_W", {30'h0, src_w}, {30'h0, vecs[i].e_src});
    end

    // Load, immediate grant, response next cycle
    ld = mk(32'h100, 32'h0, 32'h204, 4'd5, 1'b1, 2'b01, 1'b0);
    step(ld, 1'b1, 1'b0, 32'h0);
    chk("ld_stall", {31'h0, last_stall}, 32'h1);
    chk("ld_bubble_regwrite", {31'h0, rw_w}, 32'h0);
    step(ld, 1'b0, 1'b1, 32'hDEADBEEF);
    chk("ld_retire_stall", {31'h0, last_stall}, 32'h0);
    chk("ld_read_W", read_w, 32'hDEADBEEF);
    chk("ld_src_W", {30'h0, src_w}, 32'h1);
    chk("ld_rd_W", {28'h0, rd_w}, 32'h5);

    // Store, grant after 3 cycles, response 2 cycles after grant
    st = mk(32'h40, 32'h55, 32'h300, 4'd1, 1'b0, 2'b00, 1'b1);
    req_cnt = 0; stall_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step((i == 0) ? st : mk($urandom, $urandom, $urandom, 4'($urandom), 1'b1, 2'b01, 1'b1),
           (i == 3), (i == 5) || (i == 1), 32'hCAFE_F00D);
      if (last_req) req_cnt++;
      if (last_stall) stall_cnt++;
      if (i < 5) chk("st_bubble_regwrite", {31'h0, rw_w}, 32'h0);
    end
    chk("st_req_cycles", req_cnt, 4);
    chk("st_stall_cycles", stall_cnt, 5);
    chk("st_alu_W", alu_w, 32'h40);
    chk("st_read_W", read_w, 32'h0);
    chk("st_regwrite_W", {31'h0, rw_w}, 32'h0);

    // Back-to-back loads
    ld2 = mk(32'h104, 32'h0, 32'h208, 4'd6, 1'b1, 2'b01, 1'b0);
    rw_cnt = 0;
    step(ld, 1'b1, 1'b0, 32'h0);       if (rw_w) rw_cnt++;
    step(ld, 1'b0, 1'b1, 32'h1111);    if (rw_w) rw_cnt++;
    chk("b2b_first_read_W", read_w, 32'h1111);
    step(ld2, 1'b1, 1'b0, 32'h0);      if (rw_w) rw_cnt++;
    step(ld2, 1'b0, 1'b1, 32'h2222);   if (rw_w) rw_cnt++;
    chk("b2b_second_read_W", read_w, 32'h2222);
    chk("b2b_second_rd_W", {28'h0, rd_w}, 32'h6);
    chk("b2b_regwrite_count", rw_cnt, 2);

    // Reset while waiting for a response; late response must be dropped
    step(ld, 1'b1, 1'b0, 32'h0);
    do_reset();
    idle_op = mk(32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00, 1'b0);
    step(idle_op, 1'b0, 1'b1, 32'hBAD0_BAD0);
    zero_w_checks("after_rst");
    chk("after_rst_stall", {31'h0, last_stall}, 32'h0);
    // Memory op accepted on the first edge after reset release
    do_reset();
    step(ld, 1'b1, 1'b0, 32'h0);
    chk("post_rst_req", {31'h0, last_req}, 32'h1);
    step(ld, 1'b0, 1'b1, 32'h3333);
    chk("post_rst_read_W", read_w, 32'h3333);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        step(mk($urandom, $urandom, $urandom, 4'($urandom), 1'($urandom),
                2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0)),
             1'($urandom), ($urandom_range(0, 2) == 0), $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
